// File: rtl/hbuf_rdout_streamer_if.sv
// DPRAM-side handshake/read port and 16-bit output stream of the readout streamer.
// master = the streamer, slave = the reader/DPRAM/consumer side.
interface hbuf_rdout_streamer_if #(
  parameter int P_RD_ADDR_WIDTH = 9,
  parameter int P_LEN_WIDTH     = 16
);
  logic                       dpram_run;
  logic [P_LEN_WIDTH-1:0]     dpram_len;
  logic                       dpram_busy;
  logic [P_RD_ADDR_WIDTH-1:0] rd_addr;
  logic [63:0]                rd_data;
  logic [15:0]                out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  modport master (
    input  dpram_run, dpram_len, rd_data, out_ready,
    output dpram_busy, rd_addr, out_data, out_valid, out_last
  );

  modport slave (
    output dpram_run, dpram_len, rd_data, out_ready,
    input  dpram_busy, rd_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/hbuf_rdout_streamer.sv
// Drains a filled 64-bit DPRAM line by line and serialises each line into
// 16-bit valid/ready words, owning the buffer (dpram_busy) until the last word.
module hbuf_rdout_streamer #(
  parameter int P_RD_ADDR_WIDTH = 9,
  parameter int P_LEN_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  hbuf_rdout_streamer_if.master        bus,
  output logic                         buf_done,
  output logic                         len_err,
  output logic [31:0]                  n_buffers
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Four 16-bit words per line over the whole read-port address space.
  localparam logic [31:0] LEN_MAX = 32'd4 << P_RD_ADDR_WIDTH;

  logic [2:0]                 state_reg,  state_next;
  logic [P_LEN_WIDTH-1:0]     words_reg,  words_next;
  logic [1:0]                 idx_reg,    idx_next;
  logic [63:0]                line_reg,   line_next;
  logic                       busy_reg,   busy_next;
  logic [P_RD_ADDR_WIDTH-1:0] addr_reg,   addr_next;
  logic                       done_reg,   done_next;
  logic                       err_reg,    err_next;
  logic [31:0]                count_reg,  count_next;

  logic        len_ok;
  logic        emit;
  logic [15:0] line_words [4];

  assign len_ok = (32'(bus.dpram_len) != 32'd0) && (32'(bus.dpram_len) <= LEN_MAX);
  assign emit   = (state_reg == S_EMIT);

  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign line_words[gi] = line_reg[16*gi +: 16];
  end

  always_comb begin
    state_next = state_reg;
    words_next = words_reg;
    idx_next   = idx_reg;
    line_next  = line_reg;
    busy_next  = busy_reg;
    addr_next  = addr_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    count_next = count_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.dpram_run) begin
          if (len_ok) begin
            words_next = bus.dpram_len;
            busy_next  = 1'b1;
            addr_next  = '0;
            state_next = S_ADDR;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_ADDR: state_next = S_WAIT;
      S_WAIT: begin
        line_next  = bus.rd_data;
        idx_next   = 2'd0;
        state_next = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          words_next = words_reg - P_LEN_WIDTH'(1);
          idx_next   = idx_reg + 2'd1;
          // A partial last line ends on words_left, never on the word index.
          if (words_reg == P_LEN_WIDTH'(1)) begin
            state_next = S_DONE;
          end else if (idx_reg == 2'd3) begin
            addr_next  = addr_reg + P_RD_ADDR_WIDTH'(1);
            state_next = S_ADDR;
          end
        end
      end
      S_DONE: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        count_next = count_reg + 32'd1;
        addr_next  = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      words_reg <= '0;
      idx_reg   <= 2'd0;
      line_reg  <= 64'd0;
      busy_reg  <= 1'b0;
      addr_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      words_reg <= words_next;
      idx_reg   <= idx_next;
      line_reg  <= line_next;
      busy_reg  <= busy_next;
      addr_reg  <= addr_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

  assign bus.dpram_busy = busy_reg;
  assign bus.rd_addr    = addr_reg;
  assign bus.out_valid  = emit;
  assign bus.out_data   = emit ? line_words[idx_reg] : 16'd0;
  assign bus.out_last   = emit && (words_reg == P_LEN_WIDTH'(1));
  assign buf_done       = done_reg;
  assign len_err        = err_reg;
  assign n_buffers      = count_reg;

endmodule
